// File: rtl/pst_train_sched.sv
// pst_train_sched: training scheduler for the two-layer phase-coded hierarchy.
// Generates the shared phase clock and steps through warm-up, hierarchical
// learning and frozen inference, judging convergence/surprise once per cycle.
module pst_train_sched #(
  parameter int PERIOD          = 256,
  parameter int WARMUP_CYCLES   = 16,
  parameter int CONV_THRESH     = 8,
  parameter int CONV_CYCLES     = 4,
  parameter int SURPRISE_THRESH = 64,
  parameter int MAX_CYCLES      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        abort,
  input  logic        fired_L1,
  input  logic [7:0]  error_L2,
  input  logic [7:0]  error_L3,
  output logic [7:0]  global_phase,
  output logic        cycle_start,
  output logic        l3_freeze,
  output logic [2:0]  state,
  output logic [15:0] cycle_count,
  output logic [7:0]  surprise_count,
  output logic        busy,
  output logic        converged,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_HIER   = 3'd2,
    ST_CONV   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [7:0]  LP_LAST_PHASE  = 8'(PERIOD - 1);
  localparam logic [16:0] LP_WARMUP      = 17'(WARMUP_CYCLES);
  localparam logic [15:0] LP_MAX         = 16'(MAX_CYCLES);
  localparam logic [7:0]  LP_CONV_THRESH = 8'(CONV_THRESH);
  localparam logic [7:0]  LP_CONV_CYCLES = 8'(CONV_CYCLES);
  localparam logic [7:0]  LP_SURPRISE    = 8'(SURPRISE_THRESH);

  state_t      r_state;
  logic [7:0]  r_phase;
  logic        r_cycle_start;
  logic        r_l3_freeze;
  logic [15:0] r_cycle_count;
  logic [7:0]  r_surprise;
  logic        r_busy;
  logic        r_conv;
  logic        r_done;
  logic        r_timeout;
  logic [7:0]  r_stable;
  logic        r_fired;
  logic        r_stop;

  state_t      w_state_nxt;
  logic [7:0]  w_phase_nxt;
  logic        w_cycle_start_nxt;
  logic        w_l3_freeze_nxt;
  logic [15:0] w_cycle_count_nxt;
  logic [7:0]  w_surprise_nxt;
  logic        w_busy_nxt;
  logic        w_conv_nxt;
  logic        w_done_nxt;
  logic        w_timeout_nxt;
  logic [7:0]  w_stable_nxt;
  logic        w_fired_nxt;
  logic        w_stop_nxt;

  logic        w_eoc;
  logic [15:0] w_cycle_inc;
  logic        w_warm_done;
  logic        w_stable_cycle;
  logic [7:0]  w_stable_inc;
  logic        w_stop_req;

  assign w_eoc          = r_busy && (r_phase == LP_LAST_PHASE);
  assign w_cycle_inc    = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 16'd1;
  assign w_warm_done    = ({1'b0, r_cycle_count} + 17'd1) == LP_WARMUP;
  // A spike on the closing tick still belongs to this cycle.
  assign w_stable_cycle = (error_L2 <= LP_CONV_THRESH) && (error_L3 <= LP_CONV_THRESH) &&
                          (r_fired || fired_L1);
  assign w_stable_inc   = w_stable_cycle ? r_stable + 8'd1 : '0;
  assign w_stop_req     = r_stop || stop;

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_cycle_count_nxt = r_cycle_count;
    w_surprise_nxt    = r_surprise;
    w_timeout_nxt     = r_timeout;
    w_stable_nxt      = r_stable;
    w_fired_nxt       = r_fired;
    w_stop_nxt        = r_stop;

    if (abort) begin
      w_state_nxt       = ST_IDLE;
      w_phase_nxt       = '0;
      w_cycle_count_nxt = '0;
      w_surprise_nxt    = '0;
      w_timeout_nxt     = 1'b0;
      w_stable_nxt      = '0;
      w_fired_nxt       = 1'b0;
      w_stop_nxt        = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_nxt       = ST_WARMUP;
            w_phase_nxt       = '0;
            w_cycle_count_nxt = '0;
            w_surprise_nxt    = '0;
            w_timeout_nxt     = 1'b0;
            w_stable_nxt      = '0;
            w_fired_nxt       = 1'b0;
            w_stop_nxt        = 1'b0;
          end
        end
        ST_WARMUP, ST_HIER, ST_CONV: begin
          w_phase_nxt = (r_phase == LP_LAST_PHASE) ? '0 : r_phase + 8'd1;
          w_fired_nxt = r_fired || fired_L1;
          w_stop_nxt  = w_stop_req;
          if (w_eoc) begin
            w_fired_nxt       = 1'b0;
            w_cycle_count_nxt = w_cycle_inc;
            // Decisions tested in priority order: stop, timeout, convergence, surprise, warm-up.
            if (w_stop_req) begin
              w_state_nxt   = ST_DONE;
              w_timeout_nxt = 1'b0;
              w_stop_nxt    = 1'b0;
            end else if ((r_state != ST_CONV) && (w_cycle_inc >= LP_MAX)) begin
              w_state_nxt   = ST_DONE;
              w_timeout_nxt = 1'b1;
            end else if (r_state == ST_HIER) begin
              if (w_stable_inc == LP_CONV_CYCLES) begin
                w_state_nxt  = ST_CONV;
                w_stable_nxt = '0;
              end else begin
                w_stable_nxt = w_stable_inc;
              end
            end else if (r_state == ST_CONV) begin
              if (error_L2 > LP_SURPRISE) begin
                w_state_nxt    = ST_HIER;
                w_surprise_nxt = (r_surprise == '1) ? r_surprise : r_surprise + 8'd1;
              end
            end else if (w_warm_done) begin
              w_state_nxt = ST_HIER;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = '0;
        end
      endcase
    end

    w_busy_nxt        = (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_HIER) ||
                        (w_state_nxt == ST_CONV);
    w_conv_nxt        = (w_state_nxt == ST_CONV);
    w_done_nxt        = (w_state_nxt == ST_DONE);
    w_l3_freeze_nxt   = (w_state_nxt != ST_HIER);
    w_cycle_start_nxt = w_busy_nxt && (w_phase_nxt == '0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_cycle_start <= 1'b0;
      r_l3_freeze   <= 1'b1;
      r_cycle_count <= '0;
      r_surprise    <= '0;
      r_busy        <= 1'b0;
      r_conv        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_stable      <= '0;
      r_fired       <= 1'b0;
      r_stop        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_cycle_start <= w_cycle_start_nxt;
      r_l3_freeze   <= w_l3_freeze_nxt;
      r_cycle_count <= w_cycle_count_nxt;
      r_surprise    <= w_surprise_nxt;
      r_busy        <= w_busy_nxt;
      r_conv        <= w_conv_nxt;
      r_done        <= w_done_nxt;
      r_timeout     <= w_timeout_nxt;
      r_stable      <= w_stable_nxt;
      r_fired       <= w_fired_nxt;
      r_stop        <= w_stop_nxt;
    end
  end

  assign global_phase   = r_phase;
  assign cycle_start    = r_cycle_start;
  assign l3_freeze      = r_l3_freeze;
  assign state          = r_state;
  assign cycle_count    = r_cycle_count;
  assign surprise_count = r_surprise;
  assign busy           = r_busy;
  assign converged      = r_conv;
  assign done           = r_done;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_pst_train_sched.sv
// Bench for pst_train_sched: directed schedule scenarios plus a randomized run,
// all compared against a per-tick behavioural model of the run schedule.
`timescale 1ns/1ps
module tb_pst_train_sched;
  localparam int TB_P   = 8;
  localparam int TB_WU  = 2;
  localparam int TB_CT  = 8;
  localparam int TB_CC  = 3;
  localparam int TB_SUR = 64;
  localparam int TB_MX  = 20;

  logic        clk = 1'b0;
  logic        rst, start, stop, abort, fired_L1;
  logic [7:0]  error_L2, error_L3;
  logic [7:0]  global_phase;
  logic        cycle_start, l3_freeze;
  logic [2:0]  state;
  logic [15:0] cycle_count;
  logic [7:0]  surprise_count;
  logic        busy, converged, done, timeout;

  pst_train_sched #(
    .PERIOD(TB_P), .WARMUP_CYCLES(TB_WU), .CONV_THRESH(TB_CT),
    .CONV_CYCLES(TB_CC), .SURPRISE_THRESH(TB_SUR), .MAX_CYCLES(TB_MX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
    .fired_L1(fired_L1), .error_L2(error_L2), .error_L3(error_L3),
    .global_phase(global_phase), .cycle_start(cycle_start), .l3_freeze(l3_freeze),
    .state(state), .cycle_count(cycle_count), .surprise_count(surprise_count),
    .busy(busy), .converged(converged), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {state, phase, cycle_start, l3_freeze, cycle_count, surprise_count, busy, converged, done, timeout}
  logic [40:0] w_dut;
  assign w_dut = {state, global_phase, cycle_start, l3_freeze, cycle_count, surprise_count,
                  busy, converged, done, timeout};
  localparam logic [40:0] RST_VEC = {3'd0, 8'd0, 1'b0, 1'b1, 16'd0, 8'd0, 4'b0000};

  // Model: mode 0 idle, 1 warm-up, 2 learning, 3 converged, 4 done.
  int m_mode, m_phase, m_cycles, m_surp, m_stab;
  bit m_fired, m_stop, m_to;
  logic [7:0] cur_e2, cur_e3;

  function automatic logic [40:0] exp_vec();
    logic b;
    b = (m_mode >= 1) && (m_mode <= 3);
    return {3'(m_mode), 8'(m_phase), (b && m_phase == 0), (m_mode != 2), 16'(m_cycles),
            8'(m_surp), b, (m_mode == 3), (m_mode == 4), m_to};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cycles = 0; m_surp = 0; m_stab = 0;
    m_fired = 0; m_stop = 0; m_to = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit ab, input bit f,
                            input int e2, input int e3);
    bit eoc, fired_cyc, stop_req, stable;
    if (ab) begin
      model_reset();
      return;
    end
    if (m_mode == 0 || m_mode == 4) begin
      if (st) begin
        m_mode = 1; m_phase = 0; m_cycles = 0; m_surp = 0; m_stab = 0;
        m_to = 0; m_fired = 0; m_stop = 0;
      end
      return;
    end
    eoc       = (m_phase == TB_P - 1);
    fired_cyc = m_fired || f;
    stop_req  = m_stop || sp;
    m_phase   = (m_phase + 1) % TB_P;
    m_fired   = fired_cyc;
    m_stop    = stop_req;
    if (!eoc) return;
    m_fired = 0;
    if (m_cycles < 65535) m_cycles++;
    stable = (e2 <= TB_CT) && (e3 <= TB_CT) && fired_cyc;
    if (stop_req) begin
      m_mode = 4; m_to = 0; m_stop = 0;
    end else if (m_mode != 3 && m_cycles >= TB_MX) begin
      m_mode = 4; m_to = 1;
    end else if (m_mode == 1) begin
      if (m_cycles == TB_WU) m_mode = 2;
    end else if (m_mode == 2) begin
      m_stab = stable ? m_stab + 1 : 0;
      if (m_stab == TB_CC) begin
        m_mode = 3; m_stab = 0;
      end
    end else if (e2 > TB_SUR) begin
      m_mode = 2;
      if (m_surp < 255) m_surp++;
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, sample 1ns later.
  task automatic step(input bit st, input bit sp, input bit ab, input bit f);
    start = st; stop = sp; abort = ab; fired_L1 = f;
    error_L2 = cur_e2; error_L3 = cur_e3;
    @(posedge clk);
    model_edge(st, sp, ab, f, cur_e2, cur_e3);
    #1;
    start = 1'b0; stop = 1'b0; abort = 1'b0; fired_L1 = 1'b0;
  endtask

  // One full phase cycle from phase 0, optionally firing at phase 3.
  task automatic run_cycle(input logic [7:0] e2, input logic [7:0] e3, input bit fire);
    cur_e2 = e2; cur_e3 = e3;
    for (int i = 0; i < TB_P; i++) step(1'b0, 1'b0, 1'b0, fire && (i == 3));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (w_dut !== RST_VEC) begin
      n_fail++; $display("FAIL reset_vec: got %h expected %h", w_dut, RST_VEC);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (w_dut !== RST_VEC) begin
      n_fail++; $display("FAIL idle_no_start: got %h expected %h", w_dut, RST_VEC);
    end
  endtask

  task automatic test_warmup();
    apply_reset();
    cur_e2 = 8'd100; cur_e3 = 8'd100;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (state !== 3'd1 || global_phase !== 8'd0 || cycle_start !== 1'b1) begin
      n_fail++; $display("FAIL start_latency: got st=%0d ph=%0d cs=%b expected st=1 ph=0 cs=1",
                         state, global_phase, cycle_start);
    end
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, 1'b0, ((k - 1) % TB_P) == 3);
      n_checks++;
      if (l3_freeze !== (k < 16)) begin
        n_fail++; $display("FAIL warmup_freeze k=%0d: got %b expected %b", k, l3_freeze, k < 16);
      end
      n_checks++;
      if (cycle_start !== ((k % 8) == 0)) begin
        n_fail++; $display("FAIL warmup_cs k=%0d: got %b expected %b", k, cycle_start, (k % 8) == 0);
      end
      n_checks++;
      if (state !== ((k < 16) ? 3'd1 : 3'd2) || global_phase !== 8'(k % 8)) begin
        n_fail++; $display("FAIL warmup_state k=%0d: got st=%0d ph=%0d", k, state, global_phase);
      end
      n_checks++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL warmup_model k=%0d: got %h expected %h", k, w_dut, exp_vec());
      end
    end
  endtask

  task automatic test_convergence();
    for (int c = 1; c <= 3; c++) begin
      run_cycle(8'd5, 8'd5, 1'b1);
      n_checks++;
      if (c < 3 && (state !== 3'd2 || converged !== 1'b0)) begin
        n_fail++; $display("FAIL conv_early c=%0d: got st=%0d conv=%b expected st=2 conv=0", c, state, converged);
      end else if (c == 3 && (state !== 3'd3 || converged !== 1'b1 || l3_freeze !== 1'b1 ||
                              cycle_count !== 16'd6 || global_phase !== 8'd0)) begin
        n_fail++; $display("FAIL conv_reached: got st=%0d conv=%b frz=%b cc=%0d expected st=3 conv=1 frz=1 cc=6",
                           state, converged, l3_freeze, cycle_count);
      end
    end
    n_checks++;
    if (w_dut !== exp_vec()) begin
      n_fail++; $display("FAIL conv_model: got %h expected %h", w_dut, exp_vec());
    end
  endtask

  task automatic test_surprise();
    run_cycle(8'd64, 8'd5, 1'b1);
    n_checks++;
    if (state !== 3'd3 || surprise_count !== 8'd0) begin
      n_fail++; $display("FAIL surprise_at_thresh: got st=%0d sc=%0d expected st=3 sc=0", state, surprise_count);
    end
    run_cycle(8'd65, 8'd5, 1'b1);
    n_checks++;
    if (state !== 3'd2 || l3_freeze !== 1'b0 || surprise_count !== 8'd1 || cycle_count !== 16'd8) begin
      n_fail++; $display("FAIL surprise_reentry: got st=%0d frz=%b sc=%0d cc=%0d expected st=2 frz=0 sc=1 cc=8",
                         state, l3_freeze, surprise_count, cycle_count);
    end
  endtask

  task automatic test_conv_silent();
    run_cycle(8'd5, 8'd5, 1'b1);
    run_cycle(8'd5, 8'd5, 1'b0);
    run_cycle(8'd5, 8'd5, 1'b1);
    run_cycle(8'd5, 8'd5, 1'b1);
    n_checks++;
    if (state !== 3'd2 || cycle_count !== 16'd12) begin
      n_fail++; $display("FAIL silent_restart: got st=%0d cc=%0d expected st=2 cc=12", state, cycle_count);
    end
    run_cycle(8'd5, 8'd5, 1'b1);
    n_checks++;
    if (state !== 3'd3 || cycle_count !== 16'd13) begin
      n_fail++; $display("FAIL silent_conv: got st=%0d cc=%0d expected st=3 cc=13", state, cycle_count);
    end
    n_checks++;
    if (w_dut !== exp_vec()) begin
      n_fail++; $display("FAIL silent_model: got %h expected %h", w_dut, exp_vec());
    end
  endtask

  task automatic test_stop();
    cur_e2 = 8'd5; cur_e3 = 8'd5;
    for (int i = 0; i < TB_P; i++) begin
      step(1'b0, i == 3, 1'b0, 1'b0);
      if (i >= 3 && i < 7) begin
        n_checks++;
        if (state !== 3'd3 || done !== 1'b0) begin
          n_fail++; $display("FAIL stop_early i=%0d: got st=%0d done=%b expected st=3 done=0", i, state, done);
        end
      end
    end
    n_checks++;
    if (state !== 3'd4 || done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 16'd14 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_done: got st=%0d done=%b to=%b cc=%0d expected st=4 done=1 to=0 cc=14",
                         state, done, timeout, cycle_count);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (state !== 3'd1 || surprise_count !== 8'd0 || cycle_count !== 16'd0 || cycle_start !== 1'b1) begin
      n_fail++; $display("FAIL restart: got st=%0d sc=%0d cc=%0d cs=%b expected st=1 sc=0 cc=0 cs=1",
                         state, surprise_count, cycle_count, cycle_start);
    end
    run_cycle(8'd100, 8'd100, 1'b1);
    run_cycle(8'd100, 8'd100, 1'b1);
    run_cycle(8'd5, 8'd5, 1'b1);
    run_cycle(8'd5, 8'd5, 1'b1);
    for (int i = 0; i < TB_P; i++) step(1'b0, i == 5, 1'b0, i == 3);
    n_checks++;
    if (state !== 3'd4 || timeout !== 1'b0 || converged !== 1'b0 || cycle_count !== 16'd5) begin
      n_fail++; $display("FAIL stop_vs_conv: got st=%0d to=%b conv=%b cc=%0d expected st=4 to=0 conv=0 cc=5",
                         state, timeout, converged, cycle_count);
    end
  endtask

  task automatic test_timeout();
    cur_e2 = 8'd100; cur_e3 = 8'd100;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      run_cycle(8'd100, 8'd100, 1'b1);
      if (c == 19) begin
        n_checks++;
        if (state !== 3'd2 || cycle_count !== 16'd19) begin
          n_fail++; $display("FAIL timeout_early: got st=%0d cc=%0d expected st=2 cc=19", state, cycle_count);
        end
      end
    end
    n_checks++;
    if (state !== 3'd4 || done !== 1'b1 || timeout !== 1'b1 || cycle_count !== 16'd20 ||
        l3_freeze !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done: got st=%0d done=%b to=%b cc=%0d expected st=4 done=1 to=1 cc=20",
                         state, done, timeout, cycle_count);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (global_phase !== 8'd0 || cycle_start !== 1'b0 || cycle_count !== 16'd20) begin
        n_fail++; $display("FAIL done_hold i=%0d: got ph=%0d cs=%b cc=%0d expected ph=0 cs=0 cc=20",
                           i, global_phase, cycle_start, cycle_count);
      end
    end
  endtask

  task automatic test_abort();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (timeout !== 1'b0 || state !== 3'd1) begin
      n_fail++; $display("FAIL restart_clears_timeout: got to=%b st=%0d expected to=0 st=1", timeout, state);
    end
    run_cycle(8'd100, 8'd100, 1'b1);
    run_cycle(8'd100, 8'd100, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (w_dut !== RST_VEC) begin
      n_fail++; $display("FAIL abort: got %h expected %h", w_dut, RST_VEC);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (global_phase !== 8'd5 || state !== 3'd1 || cycle_count !== 16'd0) begin
      n_fail++; $display("FAIL start_busy: got ph=%0d st=%0d cc=%0d expected ph=5 st=1 cc=0",
                         global_phase, state, cycle_count);
    end
    for (int i = 5; i < TB_P; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cycle_count !== 16'd1 || global_phase !== 8'd0) begin
      n_fail++; $display("FAIL start_busy_cont: got cc=%0d ph=%0d expected cc=1 ph=0", cycle_count, global_phase);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (w_dut !== RST_VEC) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", w_dut, RST_VEC);
    end
    #1 rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (w_dut !== RST_VEC) begin
      n_fail++; $display("FAIL post_reset_idle: got %h expected %h", w_dut, RST_VEC);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 7));
      if (r <= 4)      cur_e2 = 8'($urandom_range(0, 10));
      else if (r == 5) cur_e2 = 8'($urandom_range(60, 70));
      else             cur_e2 = 8'($urandom_range(100, 255));
      cur_e3 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(0, 8));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 399) == 0, $urandom_range(0, 2) != 0);
      n_checks++;
      if (w_dut !== exp_vec()) begin
        n_fail++; $display("FAIL random n=%0d: got %h expected %h", n, w_dut, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; fired_L1 = 1'b0;
    error_L2 = '0; error_L3 = '0; cur_e2 = '0; cur_e3 = '0;
    model_reset();
    test_reset();
    test_warmup();
    test_convergence();
    test_surprise();
    test_conv_silent();
    test_stop();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
